// File: rtl/ofm_in_fsm_if.sv
// ofm_in_fsm_if: DMA-side AXI-Stream ingress plus data/ctrl FIFO write ports of ofm_in_fsm
interface ofm_in_fsm_if;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [72:0] data_fifo_wdata;
    logic        data_fifo_wren;
    logic        data_fifo_afull;
    logic [63:0] ctrl_fifo_wdata;
    logic        ctrl_fifo_wren;
    logic        ctrl_fifo_full;
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, data_fifo_afull, ctrl_fifo_full,
        input  s_axis_tready, data_fifo_wdata, data_fifo_wren, ctrl_fifo_wdata, ctrl_fifo_wren
    );
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, data_fifo_afull, ctrl_fifo_full,
        output s_axis_tready, data_fifo_wdata, data_fifo_wren, ctrl_fifo_wdata, ctrl_fifo_wren
    );
endinterface

// File: rtl/ofm_in_fsm.sv
// ofm_in_fsm: TX store-and-forward ingress FSM; define OFM_IN_PAD_EN to pad short frames to C_MIN_BYTES
module ofm_in_fsm #(
    parameter int C_MIN_BYTES = 60,
    parameter int C_MAX_BYTES = 16383
) (
    input  logic tx_clk,
    input  logic tx_reset_n,
    ofm_in_fsm_if.slave bus
);
    typedef enum logic [1:0] {S_DATA, S_PAD, S_CTRL} state_t;
    state_t      state;
    logic [15:0] byte_cnt, beat_cnt, seq_num, byte_nxt;
    logic        oversize, padded;
    logic        accept, wr_en, wr_last, to_pad;
    logic [7:0]  wr_keep;
    logic [63:0] wr_data;
    logic [16:0] byte_sum;
`ifdef OFM_IN_PAD_EN
    logic [63:0] dmask;
    logic [7:0]  fin_keep;
    logic        short_last, fin_beat;
    int          rem;
`endif
    assign bus.s_axis_tready = tx_reset_n & (state == S_DATA) & ~bus.data_fifo_afull & ~bus.ctrl_fifo_full;
    always_comb begin
        accept = bus.s_axis_tvalid & bus.s_axis_tready;
`ifdef OFM_IN_PAD_EN
        for (int i = 0; i < 8; i++) dmask[8*i +: 8] = {8{bus.s_axis_tkeep[i]}};
        rem = C_MIN_BYTES - 8 * int'(beat_cnt);
        fin_keep = 8'hFF >> (8 - rem);
        short_last = bus.s_axis_tlast && ({1'b0, byte_cnt} + 17'($countones(bus.s_axis_tkeep))) < 17'(C_MIN_BYTES);
        // the beat already holding the last minimum-length byte closes the frame itself
        fin_beat = beat_cnt == 16'((C_MIN_BYTES - 1) / 8);
        to_pad = accept & short_last & ~fin_beat;
        wr_en = accept | ((state == S_PAD) & ~bus.data_fifo_afull);
        wr_last = (state == S_PAD) ? rem <= 8 : bus.s_axis_tlast & ~(short_last & ~fin_beat);
        wr_keep = (state == S_PAD) ? (rem > 8 ? 8'hFF : fin_keep) :
                  short_last ? (fin_beat ? fin_keep : 8'hFF) : bus.s_axis_tkeep;
        wr_data = (state == S_PAD) ? 64'd0 : short_last ? bus.s_axis_tdata & dmask : bus.s_axis_tdata;
`else
        to_pad = 1'b0;
        wr_en = accept;
        wr_last = bus.s_axis_tlast;
        wr_keep = bus.s_axis_tkeep;
        wr_data = bus.s_axis_tdata;
`endif
        byte_sum = {1'b0, byte_cnt} + 17'($countones(wr_keep));
        byte_nxt = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
    end
    always_ff @(posedge tx_clk) begin
        if (!tx_reset_n) begin
            state <= S_DATA;
            byte_cnt <= '0;
            beat_cnt <= '0;
            seq_num <= '0;
            oversize <= 1'b0;
            padded <= 1'b0;
            bus.data_fifo_wren <= 1'b0;
            bus.data_fifo_wdata <= '0;
            bus.ctrl_fifo_wren <= 1'b0;
            bus.ctrl_fifo_wdata <= '0;
        end else begin
            bus.data_fifo_wren <= wr_en;
            bus.ctrl_fifo_wren <= 1'b0;
            if (wr_en) begin
                bus.data_fifo_wdata <= {wr_last, wr_keep, wr_data};
                byte_cnt <= byte_nxt;
                beat_cnt <= beat_cnt + 16'(beat_cnt != 16'hFFFF);
                oversize <= oversize | (byte_nxt > 16'(C_MAX_BYTES));
            end
            case (state)
                S_DATA: if (accept && bus.s_axis_tlast) begin
                    state <= to_pad ? S_PAD : S_CTRL;
                    padded <= to_pad;
                end
`ifdef OFM_IN_PAD_EN
                S_PAD: if (wr_en && wr_last) state <= S_CTRL;
`endif
                S_CTRL: if (!bus.ctrl_fifo_full) begin
                    bus.ctrl_fifo_wren <= 1'b1;
                    bus.ctrl_fifo_wdata <= {14'd0, padded, oversize, seq_num, beat_cnt, byte_cnt};
                    seq_num <= seq_num + 16'd1;
                    byte_cnt <= '0;
                    beat_cnt <= '0;
                    oversize <= 1'b0;
                    padded <= 1'b0;
                    state <= S_DATA;
                end
                default: state <= S_DATA;
            endcase
        end
    end
endmodule
